// File: rtl/adder_arbiter.sv
// Round-robin scheduler that shares one floating-point adder between N_REQ requesters.
// One operation is in flight at a time, and the result is returned only to the requester that issued it.
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_stb,
    output logic [N_REQ-1:0]       req_ack,
    output logic [WIDTH-1:0]       resp_z,
    output logic [N_REQ-1:0]       resp_stb,
    input  logic [N_REQ-1:0]       resp_ack,
    output logic [WIDTH-1:0]       adder_a,
    output logic                   adder_a_stb,
    input  logic                   adder_a_ack,
    output logic [WIDTH-1:0]       adder_b,
    output logic                   adder_b_stb,
    input  logic                   adder_b_ack,
    input  logic [WIDTH-1:0]       adder_z,
    input  logic                   adder_z_stb,
    output logic                   adder_z_ack,
    output logic                   busy
);
    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;

    state_t           r_state, w_state_next;
    logic [GW-1:0]    r_grant, w_grant_next;
    logic [GW-1:0]    r_last, w_last_next;
    logic [WIDTH-1:0] r_op_a, w_op_a_next;
    logic [WIDTH-1:0] r_op_b, w_op_b_next;
    logic [WIDTH-1:0] r_res_z, w_res_z_next;
    logic             r_a_done, w_a_done_next;
    logic             r_b_done, w_b_done_next;
    logic [N_REQ-1:0] r_req_ack, w_req_ack_next;
    logic [N_REQ-1:0] r_resp_stb, w_resp_stb_next;
    logic             r_a_stb, w_a_stb_next;
    logic             r_b_stb, w_b_stb_next;
    logic             r_z_ack, w_z_ack_next;
    logic             r_busy, w_busy_next;

    logic [WIDTH-1:0] w_slice_a [N_REQ];
    logic [WIDTH-1:0] w_slice_b [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_slice_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign w_slice_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from last+1 upward with wrap; iterating downward lets the nearest hit win.
    logic          w_any;
    logic [GW-1:0] w_pick;
    logic [GW-1:0] w_idx;

    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = GW'((int'(r_last) + k) % N_REQ);
            if (req_stb[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    logic w_a_xfer, w_b_xfer, w_z_xfer;
    assign w_a_xfer = r_a_stb & adder_a_ack;
    assign w_b_xfer = r_b_stb & adder_b_ack;
    assign w_z_xfer = r_z_ack & adder_z_stb;

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_last_next     = r_last;
        w_op_a_next     = r_op_a;
        w_op_b_next     = r_op_b;
        w_res_z_next    = r_res_z;
        w_a_done_next   = r_a_done;
        w_b_done_next   = r_b_done;
        w_req_ack_next  = '0;
        w_resp_stb_next = r_resp_stb;
        w_a_stb_next    = r_a_stb;
        w_b_stb_next    = r_b_stb;
        w_z_ack_next    = r_z_ack;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_next           = w_pick;
                    w_op_a_next            = w_slice_a[w_pick];
                    w_op_b_next            = w_slice_b[w_pick];
                    w_req_ack_next[w_pick] = 1'b1;
                    w_a_stb_next           = 1'b1;
                    w_b_stb_next           = 1'b1;
                    w_a_done_next          = 1'b0;
                    w_b_done_next          = 1'b0;
                    w_state_next           = S_SEND;
                end
            end
            S_SEND: begin
                // The two operand channels complete independently, in either order.
                if (w_a_xfer) begin
                    w_a_stb_next  = 1'b0;
                    w_a_done_next = 1'b1;
                end
                if (w_b_xfer) begin
                    w_b_stb_next  = 1'b0;
                    w_b_done_next = 1'b1;
                end
                if ((r_a_done | w_a_xfer) && (r_b_done | w_b_xfer)) begin
                    w_z_ack_next = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_z_xfer) begin
                    w_res_z_next             = adder_z;
                    w_z_ack_next             = 1'b0;
                    w_resp_stb_next          = '0;
                    w_resp_stb_next[r_grant] = 1'b1;
                    w_state_next             = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ack[r_grant]) begin
                    w_resp_stb_next = '0;
                    w_last_next     = r_grant;
                    w_state_next    = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_last     <= GW'(N_REQ - 1);
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_res_z    <= '0;
            r_a_done   <= 1'b0;
            r_b_done   <= 1'b0;
            r_req_ack  <= '0;
            r_resp_stb <= '0;
            r_a_stb    <= 1'b0;
            r_b_stb    <= 1'b0;
            r_z_ack    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_last     <= w_last_next;
            r_op_a     <= w_op_a_next;
            r_op_b     <= w_op_b_next;
            r_res_z    <= w_res_z_next;
            r_a_done   <= w_a_done_next;
            r_b_done   <= w_b_done_next;
            r_req_ack  <= w_req_ack_next;
            r_resp_stb <= w_resp_stb_next;
            r_a_stb    <= w_a_stb_next;
            r_b_stb    <= w_b_stb_next;
            r_z_ack    <= w_z_ack_next;
            r_busy     <= w_busy_next;
        end
    end

    assign req_ack     = r_req_ack;
    assign resp_z      = r_res_z;
    assign resp_stb    = r_resp_stb;
    assign adder_a     = r_op_a;
    assign adder_a_stb = r_a_stb;
    assign adder_b     = r_op_b;
    assign adder_b_stb = r_b_stb;
    assign adder_z_ack = r_z_ack;
    assign busy        = r_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed and randomized requester traffic against a behavioural adder,
// with a round-robin and result-routing reference model.
module tb_adder_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_stb = '0;
    logic [N-1:0]   req_ack;
    logic [W-1:0]   resp_z;
    logic [N-1:0]   resp_stb;
    logic [N-1:0]   resp_ack = '0;
    logic [W-1:0]   adder_a;
    logic           adder_a_stb;
    logic           adder_a_ack = 1'b0;
    logic [W-1:0]   adder_b;
    logic           adder_b_stb;
    logic           adder_b_ack = 1'b0;
    logic [W-1:0]   adder_z = '0;
    logic           adder_z_stb = 1'b0;
    logic           adder_z_ack;
    logic           busy;

    adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
        .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
        .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
        .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
        .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // requester side and reference model state
    logic [31:0] q_a [N];
    logic [31:0] q_b [N];
    bit          pend [N];
    int          hold_cnt [N];
    logic [31:0] last_z [N];
    int          ref_last = N - 1;
    bit          inflight = 0;
    int          owner = 0;
    logic [31:0] exp_z = '0;
    int          done_cnt = 0;
    int          resp_hold = 0;
    bit          completing = 0;
    int          grant_log [$];

    // adder model knobs
    bit add_rand = 0;
    int add_lat = 2;
    int a_stall = 0;

    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Reference float add: NaN/Inf operands propagate unchanged, everything else is exact in real.
    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_f();
        int v;
        v = int'($urandom_range(0, 200)) - 100;
        return r2f(real'(v));
    endfunction

    function automatic int rr_pick(logic [N-1:0] stb, int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (stb[i]) return i;
        end
        return -1;
    endfunction

    function automatic int first_set(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_stb[i]          = pend[i];
            req_a[i*W +: W]     = q_a[i];
            req_b[i*W +: W]     = q_b[i];
        end
    endtask

    // One clock: observe after the edge, update the model, then drive the next inputs.
    task automatic step();
        bit was_completing;
        int g;
        int gobs;
        @(posedge clk);
        #1;
        was_completing = completing;
        if (req_ack !== '0) begin
            g = rr_pick(req_stb, ref_last);
            check("single_flight", 64'(inflight), 64'd0);
            check("grant", 64'(req_ack), (g < 0) ? 64'd0 : (64'd1 << g));
            gobs = first_set(req_ack);
            grant_log.push_back(gobs);
            owner    = gobs;
            inflight = 1;
            exp_z    = fadd(q_a[gobs], q_b[gobs]);
            $display("[TB] t=%0t grant %0d a=%h b=%h", $time, gobs, q_a[gobs], q_b[gobs]);
            if (hold_cnt[gobs] > 0) begin
                hold_cnt[gobs]--;
                q_a[gobs] = rnd_f();
                q_b[gobs] = rnd_f();
            end else begin
                pend[gobs] = 0;
            end
        end
        if (was_completing) begin
            completing = 0;
            check("resp_stb_clear", 64'(resp_stb), 64'd0);
            inflight       = 0;
            ref_last       = owner;
            last_z[owner]  = exp_z;
            done_cnt++;
            resp_ack       = '0;
            $display("[TB] t=%0t done %0d z=%h", $time, owner, exp_z);
        end
        if (resp_stb !== '0) begin
            check("resp_owner", 64'(resp_stb), inflight ? (64'd1 << owner) : 64'd0);
            check("resp_z", 64'(resp_z), 64'(exp_z));
            if (resp_hold > 0) begin
                resp_hold--;
                resp_ack = ~(N'(1) << owner);
            end else begin
                resp_ack   = N'(1) << owner;
                completing = 1;
            end
        end
        drive();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 64'(done_cnt), 64'(target));
    endtask

    task automatic check_zero(input string t);
        check({t, "_req_ack"}, 64'(req_ack), 64'd0);
        check({t, "_resp_stb"}, 64'(resp_stb), 64'd0);
        check({t, "_resp_z"}, 64'(resp_z), 64'd0);
        check({t, "_adder_a"}, 64'(adder_a), 64'd0);
        check({t, "_adder_a_stb"}, 64'(adder_a_stb), 64'd0);
        check({t, "_adder_b"}, 64'(adder_b), 64'd0);
        check({t, "_adder_b_stb"}, 64'(adder_b_stb), 64'd0);
        check({t, "_adder_z_ack"}, 64'(adder_z_ack), 64'd0);
        check({t, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset(input string t);
        for (int i = 0; i < N; i++) begin
            pend[i]     = 0;
            hold_cnt[i] = 0;
        end
        drive();
        resp_ack  = '0;
        resp_hold = 0;
        rst       = 1'b1;
        step();
        check_zero(t);
        step();
        rst        = 1'b0;
        inflight   = 0;
        completing = 0;
        ref_last   = N - 1;
        resp_ack   = '0;
    endtask

    // Behavioural adder: acts on the falling edge, using values seen during the previous cycle.
    initial begin
        bit          got_a, got_b, zbusy, p_rst, p_a_stb, p_b_stb, p_z_ack;
        logic [31:0] va, vb, p_a, p_b, zval;
        int          lat;
        got_a = 0; got_b = 0; zbusy = 0; p_rst = 0; p_a_stb = 0; p_b_stb = 0; p_z_ack = 0;
        va = '0; vb = '0; p_a = '0; p_b = '0; zval = '0; lat = 0;
        forever begin
            @(negedge clk);
            if (p_rst) begin
                got_a = 0; got_b = 0; zbusy = 0;
                adder_z_stb = 1'b0;
                adder_z     = '0;
            end else begin
                if (p_a_stb && adder_a_ack) begin got_a = 1; va = p_a; end
                if (p_b_stb && adder_b_ack) begin got_b = 1; vb = p_b; end
                if (adder_z_stb && p_z_ack) adder_z_stb = 1'b0;
                if (got_a && got_b && !zbusy) begin
                    zbusy = 1;
                    zval  = fadd(va, vb);
                    lat   = add_rand ? int'($urandom_range(0, 3)) : add_lat;
                    got_a = 0;
                    got_b = 0;
                end
                if (zbusy && !adder_z_stb) begin
                    if (lat == 0) begin
                        adder_z     = zval;
                        adder_z_stb = 1'b1;
                        zbusy       = 0;
                    end else begin
                        lat--;
                    end
                end
            end
            p_rst   = rst;
            p_a_stb = adder_a_stb;
            p_a     = adder_a;
            p_b_stb = adder_b_stb;
            p_b     = adder_b;
            p_z_ack = adder_z_ack;
            if (a_stall > 0 && adder_a_stb) begin
                adder_a_ack = 1'b0;
                a_stall--;
            end else begin
                adder_a_ack = !got_a && (add_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            end
            adder_b_ack = !got_b && (add_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    end

    initial begin
        int target;
        int issued;
        for (int i = 0; i < N; i++) begin
            q_a[i] = '0; q_b[i] = '0; pend[i] = 0; hold_cnt[i] = 0; last_z[i] = '0;
        end

        // reset state
        rst = 1'b1;
        drive();
        step();
        step();
        check_zero("reset");
        rst = 1'b0;

        // single request from requester 0: 2 + 1
        q_a[0] = 32'h40000000; q_b[0] = 32'h3F800000; pend[0] = 1;
        drive();
        step();
        check("t1_ack", 64'(req_ack), 64'h1);
        step();
        check("t1_ack_pulse", 64'(req_ack), 64'h0);
        check("t1_busy", 64'(busy), 64'h1);
        run_until(1, 200, "t1_done");
        check("t1_z", 64'(last_z[0]), 64'h40400000);

        // mixed signs on requester 2: 1 + -2
        q_a[2] = 32'h3F800000; q_b[2] = 32'hC0000000; pend[2] = 1;
        drive();
        target = done_cnt + 1;
        run_until(target, 200, "t2_done");
        check("t2_z", 64'(last_z[2]), 64'hBF800000);

        // all four at once after reset
        do_reset("rst2");
        grant_log.delete();
        q_a[0] = 32'h3F800000; q_b[0] = 32'h3F800000;
        q_a[1] = 32'h3F800000; q_b[1] = 32'h40000000;
        q_a[2] = 32'h40000000; q_b[2] = 32'h40000000;
        q_a[3] = 32'h40000000; q_b[3] = 32'h3F800000;
        for (int i = 0; i < N; i++) pend[i] = 1;
        drive();
        target = done_cnt + 4;
        run_until(target, 400, "t3_done");
        check("t3_ngrants", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("t3_order", 64'(grant_log[i]), 64'(i));
        check("t3_z0", 64'(last_z[0]), 64'h40000000);
        check("t3_z1", 64'(last_z[1]), 64'h40400000);
        check("t3_z2", 64'(last_z[2]), 64'h40800000);
        check("t3_z3", 64'(last_z[3]), 64'h40400000);

        // fairness: 1 and 3 hold their request line for three operations each
        grant_log.delete();
        q_a[1] = rnd_f(); q_b[1] = rnd_f(); hold_cnt[1] = 2; pend[1] = 1;
        q_a[3] = rnd_f(); q_b[3] = rnd_f(); hold_cnt[3] = 2; pend[3] = 1;
        drive();
        target = done_cnt + 6;
        run_until(target, 600, "t4_done");
        check("t4_ngrants", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) check("t4_order", 64'(grant_log[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

        // backpressure: operand a stalled, response held, second requester waiting
        grant_log.delete();
        a_stall   = 5;
        resp_hold = 20;
        q_a[0] = 32'h40000000; q_b[0] = 32'h40000000; pend[0] = 1;
        q_a[1] = 32'h3F800000; q_b[1] = 32'h3F800000; pend[1] = 1;
        drive();
        step();
        check("t5_ack", 64'(req_ack), 64'h1);
        step();
        step();
        step();
        check("t5_a_stb_held", 64'(adder_a_stb), 64'h1);
        check("t5_b_stb_done", 64'(adder_b_stb), 64'h0);
        check("t5_busy", 64'(busy), 64'h1);
        target = done_cnt + 2;
        run_until(target, 400, "t5_done");
        check("t5_z0", 64'(last_z[0]), 64'h40800000);
        check("t5_z1", 64'(last_z[1]), 64'h40000000);
        check("t5_order0", 64'(grant_log[0]), 64'd0);
        check("t5_order1", 64'(grant_log[1]), 64'd1);

        // randomized traffic with random adder handshakes and response delays
        add_rand = 1;
        issued   = 0;
        target   = done_cnt + 30;
        for (int c = 0; c < 4000 && done_cnt < target; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && issued < 30 && $urandom_range(0, 3) == 0) begin
                    q_a[i]  = rnd_f();
                    q_b[i]  = rnd_f();
                    pend[i] = 1;
                    issued++;
                end
            end
            if (resp_hold == 0 && $urandom_range(0, 7) == 0) resp_hold = int'($urandom_range(1, 4));
            drive();
            step();
        end
        check("rand_done", 64'(done_cnt), 64'(target));
        add_rand  = 0;
        resp_hold = 0;
        step();
        step();

        // reset while waiting on the adder result
        add_lat = 10;
        q_a[2] = 32'h3F800000; q_b[2] = 32'h3F800000; pend[2] = 1;
        drive();
        for (int k = 0; k < 50 && adder_z_ack !== 1'b1; k++) step();
        check("t7_reach_wait", 64'(adder_z_ack), 64'h1);
        do_reset("rst_mid");
        add_lat = 2;
        grant_log.delete();
        q_a[1] = 32'hFF800001; q_b[1] = 32'h3F800000; pend[1] = 1;
        drive();
        target = done_cnt + 1;
        run_until(target, 200, "t7_done");
        check("t7_owner", 64'(grant_log[0]), 64'd1);
        check("t7_nan", 64'(last_z[1]), 64'hFF800001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one single-precision floating-point `adder` between `N_REQ` requesters in the matrix-multiplier datapath. Each requester submits an operand pair over a stb/ack handshake. The arbiter grants one requester at a time and drives the adder's `input_a`/`input_b`/`output_z` stb/ack ports. It returns the sum only to the requester that owns the operation. Only one operation is in flight at a time.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `WIDTH`, 32: operand/result width (IEEE-754 single).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_a` in N_REQ*WIDTH: operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` in N_REQ*WIDTH: operand b, packed the same way.
- `req_stb` in N_REQ: request valid, one bit per requester.
- `req_ack` out N_REQ: one-cycle pulse on the granted bit; operands have been captured.
- `resp_z` out WIDTH: result, broadcast to all requesters.
- `resp_stb` out N_REQ: result valid, raised on the owner's bit only.
- `resp_ack` in N_REQ: result consumed.
- `adder_a` out WIDTH: to adder `input_a`.
- `adder_a_stb` out 1 / `adder_a_ack` in 1: handshake for operand a.
- `adder_b` out WIDTH: to adder `input_b`.
- `adder_b_stb` out 1 / `adder_b_ack` in 1: handshake for operand b.
- `adder_z` in WIDTH: from adder `output_z`.
- `adder_z_stb` in 1 / `adder_z_ack` out 1: handshake for the result.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Handshake rule (all channels):** a transfer occurs on a rising edge where stb and ack are both high.
  - The source holds data and stb stable until the transfer.
  - Requesters must not drop `req_stb` before `req_ack`.
- **Registers:** `state`, `grant` (log2 N_REQ), `last` (pointer), `op_a`, `op_b`, `res_z`, `a_done`, `b_done`. All outputs are registered.
- **Reset:**
  - state=IDLE, `last`=N_REQ-1 (requester 0 has first priority).
  - All stb/ack outputs are 0; all data outputs are 0; `busy`=0.
  - `rst` mid-operation discards the in-flight operation; no response is issued. The adder shares `rst`.
- **IDLE:**
  - If any `req_stb` bit is set, grant the first set bit scanning from `last+1` with wrap modulo N_REQ.
  - Capture `op_a` and `op_b` from that slice and pulse `req_ack[grant]`.
  - Go to SEND, with `adder_a_stb` and `adder_b_stb` both set and `a_done`=`b_done`=0.
- **SEND:**
  - `adder_a_stb` drops on the a transfer; `adder_b_stb` drops on the b transfer. The transfers may occur in either order or in the same cycle.
  - When both are done, go to WAIT with `adder_z_ack`=1.
- **WAIT:**
  - On the z transfer, latch `res_z`, drop `adder_z_ack`, and go to RESP with `resp_stb[grant]`=1 and `resp_z`=`res_z`.
- **RESP:**
  - Hold `resp_stb[grant]` and `resp_z` until `resp_ack[grant]`.
  - Then clear `resp_stb`, set `last`=`grant`, and go to IDLE.
  - `resp_ack` on non-granted bits is ignored.
- **Fairness:** a requester that keeps `req_stb` high is served again only after every other pending requester has been served once.
- **Simultaneous new requests:** requests that arrive while busy wait in their stb; they are evaluated only in IDLE.
- **Data values:** NaN, infinity and denormal operands pass through unmodified. All arithmetic is done by the adder.

## Timing
- Request seen in IDLE at edge t: `req_ack` is high and the stbs are raised during cycle t+1.
- With a zero-wait adder (acks already high), operands transfer at edge t+2.
- The result appears `adder latency` cycles after the operand transfer. `resp_stb` rises one cycle after the z transfer.
- After `resp_ack`, the FSM is back in IDLE the next cycle. IDLE costs one cycle before the next grant.
  - Back-to-back throughput is one operation per (adder latency + 5) cycles, best case.
- `busy` equals (state != IDLE), registered.

## Test plan
- **Single request:** requester 0 sends a=0x40000000, b=0x3F800000.
  - Expect a one-cycle `req_ack[0]`.
  - Expect `resp_stb[0]` with `resp_z`=0x40400000; other `resp_stb` bits stay 0.
- **Mixed signs:** requester 2 sends 0x3F800000 + 0xC0000000.
  - Expect `resp_z`=0xBF800000 on `resp_stb[2]`.
- **All four requesters** raise `req_stb` together after reset, each with distinct operands (1+1, 1+2, 2+2, 2+1).
  - Expect grants in order 0,1,2,3.
  - Expect results 0x40000000, 0x40400000, 0x40800000, 0x40400000, each to its owner.
- **Fairness:** requesters 1 and 3 hold `req_stb` continuously for 6 operations.
  - Expect grants alternating 1,3,1,3,1,3; requester 3's `req_stb` is never starved.
- **Backpressure:** hold `resp_ack` low for 20 cycles in RESP, and independently stall `adder_a_ack` for 5 cycles while `adder_b_ack` is high.
  - Expect `resp_stb` and `resp_z` stable, no new grant, and `adder_a_stb` still high; the final result is correct.
- **Reset mid-operation:** assert `rst` during WAIT.
  - Expect all outputs 0, `busy`=0 and no `resp_stb` on the next edge.
  - After release, a fresh request (NaN 0xFF800001 + 0x3F800000) completes and returns the adder's NaN output to its owner.
